// File: rtl/ecg_trace_renderer.sv
// Scrolling ECG trace renderer: circular sample buffer plus a 3-stage hcount->pixel pipeline.
// Define ECG_GRID_EN to draw a background grid every 64 pixels.
module ecg_trace_renderer #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned Y_TOP       = 256,
    parameter logic [11:0] TRACE_COLOR = 12'hF00,
    parameter logic [11:0] GRID_COLOR  = 12'h222
) (
    input  logic        vga_clock,
    input  logic        reset_n,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [7:0]  sample_data,
    input  logic        freeze,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        at_display_area_in,
    output logic [11:0] pixel,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        at_display_area_out
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, base_ptr_q, rd_addr;
    logic [FW-1:0] fill_q, fill_snap_q;
    logic          frozen_q, vsync_prev_q;
    logic          write_en, vsync_fall;

    assign sample_ready = ~frozen_q;
    assign write_en     = sample_valid & sample_ready;
    assign vsync_fall   = vsync_prev_q & ~vsync_in;

    always_ff @(posedge vga_clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            base_ptr_q   <= '0;
            fill_snap_q  <= '0;
            frozen_q     <= 1'b0;
            vsync_prev_q <= 1'b1;
        end else begin
            vsync_prev_q <= vsync_in;
            if (write_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (fill_q != FW'(DEPTH)) fill_q <= fill_q + 1'b1;
            end
            // Snapshot sees pre-write pointer/fill, keeping the frame consistent.
            if (vsync_fall) begin
                base_ptr_q  <= wr_ptr_q;
                fill_snap_q <= fill_q;
                frozen_q    <= freeze;
            end
        end
    end

    // Stage 1: address and column blanking; RAM read registered.
    logic [7:0]  rd_data_q;
    logic        blank_s1, blank_d1_q;
    logic [10:0] hcount_d1_q;
    logic [9:0]  vcount_d1_q;
    logic [11:0] hcount_ext, blank_lim;

    assign rd_addr    = base_ptr_q + hcount[AW-1:0];
    assign hcount_ext = 12'(hcount);
    assign blank_lim  = 12'(DEPTH) - 12'(fill_snap_q);
    assign blank_s1   = (hcount_ext >= 12'(DEPTH)) | (hcount_ext < blank_lim);

    always_ff @(posedge vga_clock) begin
        if (write_en) mem_q[wr_ptr_q] <= sample_data;
        rd_data_q <= mem_q[rd_addr];
    end

    // Stage 2: sample value to screen line, paired with the previous column.
    logic [9:0] y_cur_s2, y_prev_s2, y_cur_q, y_prev_q;
    logic       blank_d2_q;
    logic [9:0] vcount_d2_q;
`ifdef ECG_GRID_EN
    logic [10:0] hcount_d2_q;
`endif

    assign y_cur_s2  = 10'(Y_TOP) + 10'(8'd255 - rd_data_q);
    // A column following a blank one has no neighbour to join to.
    assign y_prev_s2 = (hcount_d1_q == 11'd0 || blank_d2_q) ? y_cur_s2 : y_cur_q;

    // Stage 3: vertical span between adjacent samples.
    logic [9:0]  y_lo, y_hi;
    logic        lit;
    logic [11:0] background, pixel_d, pixel_q;
    logic [2:0]  hs_q, vs_q, de_q;

    assign y_lo = (y_prev_q < y_cur_q) ? y_prev_q : y_cur_q;
    assign y_hi = (y_prev_q < y_cur_q) ? y_cur_q : y_prev_q;
    assign lit  = ~blank_d2_q && (vcount_d2_q >= y_lo) && (vcount_d2_q <= y_hi);

`ifdef ECG_GRID_EN
    assign background = (hcount_d2_q[5:0] == 6'd0 || vcount_d2_q[5:0] == 6'd0) ?
                        GRID_COLOR : 12'h000;
`else
    assign background = 12'h000;
`endif

    always_comb begin
        pixel_d = 12'h000;
        if (de_q[1]) pixel_d = lit ? TRACE_COLOR : background;
    end

    always_ff @(posedge vga_clock or negedge reset_n) begin
        if (!reset_n) begin
            blank_d1_q  <= 1'b1;
            hcount_d1_q <= '0;
            vcount_d1_q <= '0;
            y_cur_q     <= '0;
            y_prev_q    <= '0;
            blank_d2_q  <= 1'b1;
            vcount_d2_q <= '0;
`ifdef ECG_GRID_EN
            hcount_d2_q <= '0;
`endif
            pixel_q     <= '0;
            hs_q        <= 3'b111;
            vs_q        <= 3'b111;
            de_q        <= 3'b000;
        end else begin
            blank_d1_q  <= blank_s1;
            hcount_d1_q <= hcount;
            vcount_d1_q <= vcount;
            y_cur_q     <= y_cur_s2;
            y_prev_q    <= y_prev_s2;
            blank_d2_q  <= blank_d1_q;
            vcount_d2_q <= vcount_d1_q;
`ifdef ECG_GRID_EN
            hcount_d2_q <= hcount_d1_q;
`endif
            pixel_q     <= pixel_d;
            hs_q        <= {hs_q[1:0], hsync_in};
            vs_q        <= {vs_q[1:0], vsync_in};
            de_q        <= {de_q[1:0], at_display_area_in};
        end
    end

    assign pixel               = pixel_q;
    assign hsync_out           = hs_q[2];
    assign vsync_out           = vs_q[2];
    assign at_display_area_out = de_q[2];

endmodule

// File: tb/tb_ecg_trace_renderer.sv
// Directed self-checking bench for ecg_trace_renderer (default DEPTH=1024, Y_TOP=256).
module tb_ecg_trace_renderer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        sample_valid, sample_ready, freeze;
    logic [7:0]  sample_data;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync_in, vsync_in, de_in;
    logic [11:0] pixel;
    logic        hsync_out, vsync_out, de_out;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    ecg_trace_renderer dut (
        .vga_clock          (clk),
        .reset_n            (reset_n),
        .sample_valid       (sample_valid),
        .sample_ready       (sample_ready),
        .sample_data        (sample_data),
        .freeze             (freeze),
        .hcount             (hcount),
        .vcount             (vcount),
        .hsync_in           (hsync_in),
        .vsync_in           (vsync_in),
        .at_display_area_in (de_in),
        .pixel              (pixel),
        .hsync_out          (hsync_out),
        .vsync_out          (vsync_out),
        .at_display_area_out(de_out)
    );

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = d;
    endtask

    task automatic end_push();
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic frame_edge();
        @(negedge clk);
        vsync_in = 1'b0;
        @(negedge clk);
        vsync_in = 1'b1;
    endtask

    // Drive column h-1 then h; the pixel for h is visible 3 edges after h is applied.
    task automatic probe(input logic [10:0] h, input logic [9:0] v, input logic de);
        @(negedge clk);
        vcount = v;
        de_in  = de;
        hcount = (h == 11'd0) ? 11'd0 : h - 11'd1;
        @(negedge clk);
        hcount = h;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; sample_valid = 1'b0; sample_data = 8'd0; freeze = 1'b0;
        hcount = 11'd0; vcount = 10'd0; hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Drive outputs away from reset values, then reset asynchronously mid-line.
        @(negedge clk);
        hcount = 11'd500; vcount = 10'd300; de_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_pixel", pixel, 12'h000);
        check("rst_hsync", {11'd0, hsync_out}, 12'd1);
        check("rst_vsync", {11'd0, vsync_out}, 12'd1);
        check("rst_de", {11'd0, de_out}, 12'd0);
        check("rst_ready", {11'd0, sample_ready}, 12'd1);
        @(negedge clk);
        hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Sync latency at hcount 1047.
        hcount = 11'd1047;
        repeat (4) @(negedge clk);
        hsync_in = 1'b0;
        repeat (2) @(negedge clk);
        check("lat_hs_2cyc", {11'd0, hsync_out}, 12'd1);
        @(negedge clk);
        check("lat_hs_3cyc", {11'd0, hsync_out}, 12'd0);
        hsync_in = 1'b1;

        // Partial fill: 10 samples of 128.
        for (int i = 0; i < 10; i++) push(8'd128);
        end_push();
        probe(11'd1023, 10'd383, 1'b1);
        check("nosnap_1023", pixel, 12'h000);
        frame_edge();
        probe(11'd1014, 10'd383, 1'b1);
        check("part_1014", pixel, 12'hF00);
        probe(11'd1023, 10'd383, 1'b1);
        check("part_1023", pixel, 12'hF00);
        probe(11'd1013, 10'd383, 1'b1);
        check("part_1013", pixel, 12'h000);
        probe(11'd0, 10'd383, 1'b1);
        check("part_0", pixel, 12'h000);
        probe(11'd1014, 10'd382, 1'b1);
        check("part_l382", pixel, 12'h000);
        probe(11'd1014, 10'd384, 1'b1);
        check("part_l384", pixel, 12'h000);
        probe(11'd1014, 10'd383, 1'b0);
        check("part_nodisp", pixel, 12'h000);
        check("part_de_out", {11'd0, de_out}, 12'd0);
        probe(11'd1030, 10'd383, 1'b1);
        check("part_h1030", pixel, 12'h000);

        // Wrap: 1030 samples, value = i[7:0].
        do_reset();
        for (int i = 0; i < 1030; i++) push(8'(i));
        end_push();
        frame_edge();
        probe(11'd0, 10'd505, 1'b1);
        check("wrap_c0_505", pixel, 12'hF00);
        probe(11'd0, 10'd506, 1'b1);
        check("wrap_c0_506", pixel, 12'h000);
        probe(11'd1023, 10'd506, 1'b1);
        check("wrap_c1023_506", pixel, 12'hF00);
        probe(11'd1023, 10'd508, 1'b1);
        check("wrap_c1023_508", pixel, 12'h000);

        // Slope: column 250 holds value 0, column 249 holds 255.
        probe(11'd250, 10'd256, 1'b1);
        check("slope_256", pixel, 12'hF00);
        probe(11'd250, 10'd400, 1'b1);
        check("slope_400", pixel, 12'hF00);
        probe(11'd250, 10'd511, 1'b1);
        check("slope_511", pixel, 12'hF00);
        probe(11'd250, 10'd255, 1'b1);
        check("slope_255", pixel, 12'h000);
        probe(11'd249, 10'd300, 1'b1);
        check("slope_c249", pixel, 12'h000);

        // Freeze: no writes accepted, trace held across frames.
        freeze = 1'b1;
        frame_edge();
        check("frz_ready", {11'd0, sample_ready}, 12'd0);
        for (int i = 0; i < 20; i++) push(8'd0);
        end_push();
        for (int f = 0; f < 3; f++) begin
            frame_edge();
            probe(11'd0, 10'd505, 1'b1);
            check($sformatf("frz_f%0d_c0", f), pixel, 12'hF00);
            probe(11'd1023, 10'd506, 1'b1);
            check($sformatf("frz_f%0d_c1023", f), pixel, 12'hF00);
        end
        probe(11'd64, 10'd0, 1'b1);
`ifdef ECG_GRID_EN
        check("grid_64_0", pixel, 12'h222);
`else
        check("grid_64_0", pixel, 12'h000);
`endif
        freeze = 1'b0;
        frame_edge();
        check("unfrz_ready", {11'd0, sample_ready}, 12'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
